// File: rtl/spc_addr_pkg.sv
// Shared definitions for the operand-address sequencer: addressing-mode codes,
// sequencer states and width helpers.
package spc_addr_pkg;

  localparam logic [2:0] MODE_IMM     = 3'd0;
  localparam logic [2:0] MODE_DP      = 3'd1;
  localparam logic [2:0] MODE_DP_IDX  = 3'd2;
  localparam logic [2:0] MODE_ABS     = 3'd3;
  localparam logic [2:0] MODE_ABS_IDX = 3'd4;
  localparam logic [2:0] MODE_IND_Y   = 3'd5;
  localparam logic [2:0] MODE_X_IND   = 3'd6;
  localparam logic [2:0] MODE_REL     = 3'd7;

  typedef enum logic [1:0] {IDLE, OPND, PTR} seq_state_e;

  // Bytes per absolute operand or pointer.
  function automatic int nb_of(input int aw);
    return aw / 8;
  endfunction

  function automatic int isel_w(input int nidx);
    return (nidx > 1) ? $clog2(nidx) : 1;
  endfunction

endpackage

// File: rtl/spc_addr_seq_pc.sv
// Program counter: reset value, load, increment, all gated by the clock enable.
module spc_addr_seq_pc #(
  parameter int          AW    = 16,
  parameter int unsigned RSTPC = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          LOAD,
  input  logic          INC,
  input  logic [AW-1:0] DIN,
  output logic [AW-1:0] PC
);

  logic [AW-1:0] pc_q;

  // A load with increment lets an immediate command use the freshly loaded PC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= AW'(RSTPC);
    end else if (EN) begin
      if (LOAD)     pc_q <= INC ? DIN + AW'(1) : DIN;
      else if (INC) pc_q <= pc_q + AW'(1);
    end
  end

  assign PC = pc_q;

endmodule

// File: rtl/spc_addr_seq.sv
// Operand-address sequencer: fetches operand and pointer bytes over a byte bus
// and returns one effective address per addressing-mode command.
module spc_addr_seq
  import spc_addr_pkg::*;
#(
  parameter int          AW    = 16,
  parameter int          NIDX  = 2,
  parameter int unsigned RSTPC = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [2:0]                CMD_MODE,
  input  logic [isel_w(NIDX)-1:0]   CMD_ISEL,
  input  logic [8*NIDX-1:0]         IDX,
  input  logic [AW-9:0]             DP_PAGE,
  input  logic                      PC_LOAD,
  input  logic [AW-1:0]             PC_DIN,
  output logic                      MEM_REQ,
  output logic [AW-1:0]             MEM_ADDR,
  input  logic                      MEM_ACK,
  input  logic [7:0]                MEM_RDATA,
  output logic [AW-1:0]             EA,
  output logic                      EA_VALID,
  output logic                      PAGE_X,
  output logic [AW-1:0]             PC
);

  localparam int         NB      = nb_of(AW);
  localparam int         ISW     = isel_w(NIDX);
  localparam logic [2:0] NB_LAST = 3'(NB - 1);

  seq_state_e        state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [ISW-1:0]    isel_q, isel_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-9:0]     asm_q, asm_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [AW-1:0]     ea_q, ea_d;
  logic              vld_q, vld_d;
  logic              px_q, px_d;
  logic              pc_load, pc_inc;
  logic [AW-1:0]     pc_eff;
  logic [7:0]        x_sel;
  logic [AW-1:0]     x_ext, asm_sh, rel_ea;
  logic [8:0]        sum_b, sum_lo;
  logic [2:0]        opnd_last;

  spc_addr_seq_pc #(.AW(AW), .RSTPC(RSTPC)) u_pc (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .LOAD (pc_load),
    .INC  (pc_inc),
    .DIN  (PC_DIN),
    .PC   (PC)
  );

  always_comb begin
    x_sel = '0;
    for (int k = 0; k < NIDX; k++)
      if (isel_q == ISW'(k)) x_sel = IDX[8*k +: 8];
  end

  // asm_q holds the earlier bytes of the current little-endian word; the
  // arriving byte completes it as the top byte.
  assign asm_sh    = {MEM_RDATA, asm_q};
  assign x_ext     = {{(AW-8){1'b0}}, x_sel};
  assign sum_b     = {1'b0, MEM_RDATA} + {1'b0, x_sel};
  assign sum_lo    = {1'b0, asm_sh[7:0]} + {1'b0, x_sel};
  assign rel_ea    = PC + AW'(1) + {{(AW-8){MEM_RDATA[7]}}, MEM_RDATA};
  assign opnd_last = (mode_q == MODE_ABS || mode_q == MODE_ABS_IDX) ? NB_LAST : 3'd0;
  assign pc_load   = (state_q == IDLE) && PC_LOAD;
  assign pc_eff    = PC_LOAD ? PC_DIN : PC;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    isel_d  = isel_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    ptr_d   = ptr_q;
    ea_d    = ea_q;
    px_d    = px_q;
    vld_d   = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      IDLE: if (CMD_VALID) begin
        mode_d = CMD_MODE;
        isel_d = CMD_ISEL;
        cnt_d  = '0;
        if (CMD_MODE == MODE_IMM) begin
          ea_d   = pc_eff;
          px_d   = 1'b0;
          vld_d  = 1'b1;
          pc_inc = 1'b1;
        end else begin
          state_d = OPND;
        end
      end
      OPND: if (MEM_ACK) begin
        pc_inc = 1'b1;
        asm_d  = asm_sh[AW-1:8];
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == opnd_last) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          px_d    = 1'b0;
          cnt_d   = '0;
          case (mode_q)
            MODE_DP:      ea_d = {DP_PAGE, MEM_RDATA};
            MODE_DP_IDX:  begin ea_d = {DP_PAGE, sum_b[7:0]}; px_d = sum_b[8]; end
            MODE_ABS:     ea_d = asm_sh;
            MODE_ABS_IDX: begin ea_d = asm_sh + x_ext; px_d = sum_lo[8]; end
            MODE_IND_Y:   begin state_d = PTR; vld_d = 1'b0; px_d = px_q; ptr_d = MEM_RDATA; end
            MODE_X_IND:   begin state_d = PTR; vld_d = 1'b0; px_d = px_q; ptr_d = sum_b[7:0]; end
            default:      ea_d = rel_ea;
          endcase
        end
      end
      PTR: if (MEM_ACK) begin
        // Pointer bytes stay inside the direct page: only the low byte steps.
        ptr_d = ptr_q + 8'd1;
        asm_d = asm_sh[AW-1:8];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == NB_LAST) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          cnt_d   = '0;
          if (mode_q == MODE_IND_Y) begin
            ea_d = asm_sh + x_ext;
            px_d = sum_lo[8];
          end else begin
            ea_d = asm_sh;
            px_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= MODE_IMM;
      isel_q  <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      ptr_q   <= '0;
      ea_q    <= '0;
      vld_q   <= 1'b0;
      px_q    <= 1'b0;
    end else if (EN) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      isel_q  <= isel_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ptr_q   <= ptr_d;
      ea_q    <= ea_d;
      vld_q   <= vld_d;
      px_q    <= px_d;
    end
  end

  assign CMD_READY = (state_q == IDLE);
  assign MEM_REQ   = (state_q != IDLE);
  assign MEM_ADDR  = (state_q == PTR) ? {DP_PAGE, ptr_q} : PC;
  assign EA        = ea_q;
  assign EA_VALID  = vld_q;
  assign PAGE_X    = px_q;

endmodule
